cas_tx_sequencer: RTL and testbench

- Cassette-save byte scheduler for the SVI-328 tape output path.
- Buffers CPU-written bytes in a small FIFO and frames each save session as: leader bytes, one sync byte, then the data stream.
- Drives the bit-level square-wave generator through its start/din/extend/done handshake, one byte at a time.
- Sits between the PPI/CPU cassette write register and the square-wave generator.

---
 rtl/cas_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_cas_tx_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_tx_sequencer.sv
// Cassette-save byte scheduler: FIFO-buffered CPU bytes framed as leader/sync/data for the tape square-wave generator.
// Optional trailing two's-complement checksum byte when CAS_CHECKSUM_EN is defined.
module cas_tx_sequencer #(
   parameter int unsigned FIFO_AW     = 3,
   parameter logic [15:0] LEADER_LEN  = 16'd256,
   parameter logic [7:0]  LEADER_BYTE = 8'h55,
   parameter logic [7:0]  SYNC_BYTE   = 8'h7F,
   parameter int unsigned START_HOLD  = 4,
   parameter logic [23:0] TIMEOUT     = 24'hFFFFFF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       motor_on,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       fifo_full,
   output logic       busy,
   output logic       underrun,
   output logic       timeout_err,
   output logic       gen_start,
   output logic [7:0] gen_din,
   output logic       gen_extend,
   input  logic       gen_done
);

   localparam int unsigned  DEPTH     = 2**FIFO_AW;
   localparam logic [23:0]  HOLD_LAST = 24'(START_HOLD - 1);
   localparam logic [23:0]  WDOG_LAST = TIMEOUT - 24'd1;
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_LEADER, S_SYNC, S_DATA, S_CHKSUM, S_STARTP, S_WAITLO, S_WAITHI
   } state_t;

   state_t           r_state, w_state_nx;
   state_t           r_phase, w_issue_phase, w_end_state;

   logic [7:0]       r_mem [DEPTH];
   logic [FIFO_AW:0] r_wptr, r_rptr;
   logic             r_motor_q, r_stop;
   logic [15:0]      r_lcnt;
   logic [23:0]      r_wdog;
   logic [7:0]       r_din;
   logic             r_ext, r_underrun, r_timeout;

   logic             w_motor_rise, w_stop, w_empty, w_full, w_wr_ok, w_in_byte;
   logic [7:0]       w_head, w_issue_byte;
   logic             w_issue, w_issue_ext, w_pop, w_flush, w_lcnt_dec;
   logic             w_underrun_set, w_timeout_set, w_start_session, w_complete;

`ifdef CAS_CHECKSUM_EN
   logic [7:0]       r_sum;
   logic             r_sent;
   logic [7:0]       w_chk;
   assign w_chk       = ~r_sum + 8'd1;
   assign w_end_state = r_sent ? S_CHKSUM : S_IDLE;
`else
   assign w_end_state = S_IDLE;
`endif

   assign w_motor_rise = motor_on & ~r_motor_q;
   // a fall is remembered so that a quick re-rise cannot resume the session
   assign w_stop       = r_stop | ~motor_on;
   assign w_empty      = (r_wptr == r_rptr);
   assign w_full       = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                         (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
   assign w_wr_ok      = wr_en & ~w_full;
   assign w_head       = r_mem[r_rptr[FIFO_AW-1:0]];
   assign w_in_byte    = (r_state == S_STARTP) || (r_state == S_WAITLO) || (r_state == S_WAITHI);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx      = r_state;
      w_issue         = 1'b0;
      w_issue_byte    = '0;
      w_issue_ext     = 1'b0;
      w_issue_phase   = r_phase;
      w_pop           = 1'b0;
      w_flush         = 1'b0;
      w_lcnt_dec      = 1'b0;
      w_underrun_set  = 1'b0;
      w_timeout_set   = 1'b0;
      w_start_session = 1'b0;
      w_complete      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_motor_rise) begin
               w_start_session = 1'b1;
               w_state_nx      = (LEADER_LEN == '0) ? S_SYNC : S_LEADER;
            end
         end
         S_LEADER, S_SYNC: begin
            if (w_stop) begin
               w_flush    = 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               w_issue       = 1'b1;
               w_issue_byte  = (r_state == S_LEADER) ? LEADER_BYTE : SYNC_BYTE;
               w_issue_phase = r_state;
               w_state_nx    = S_STARTP;
            end
         end
         S_DATA: begin
            if (w_stop) begin
               w_flush    = 1'b1;
               w_state_nx = w_end_state;
            end else if (!w_empty) begin
               w_pop         = 1'b1;
               w_issue       = 1'b1;
               w_issue_byte  = w_head;
               w_issue_ext   = 1'b1;
               w_issue_phase = S_DATA;
               w_state_nx    = S_STARTP;
            end else begin
               w_underrun_set = 1'b1;
            end
         end
`ifdef CAS_CHECKSUM_EN
         S_CHKSUM: begin
            w_issue       = 1'b1;
            w_issue_byte  = w_chk;
            w_issue_ext   = 1'b1;
            w_issue_phase = S_CHKSUM;
            w_state_nx    = S_STARTP;
         end
`endif
         S_STARTP: if (r_wdog == HOLD_LAST) w_state_nx = S_WAITLO;
         S_WAITLO: if (!gen_done) w_state_nx = S_WAITHI;
         S_WAITHI: begin
            if (gen_done) begin
               w_complete = 1'b1;
               case (r_phase)
                  S_LEADER: begin
                     w_lcnt_dec = 1'b1;
                     if (w_stop) begin
                        w_flush    = 1'b1;
                        w_state_nx = S_IDLE;
                     end else begin
                        w_state_nx = (r_lcnt == 16'd1) ? S_SYNC : S_LEADER;
                     end
                  end
                  S_SYNC: begin
                     if (w_stop) begin
                        w_flush    = 1'b1;
                        w_state_nx = S_IDLE;
                     end else begin
                        w_state_nx = S_DATA;
                     end
                  end
                  S_DATA: begin
                     if (w_stop) begin
                        w_flush    = 1'b1;
                        w_state_nx = w_end_state;
                     end else begin
                        w_state_nx = S_DATA;
                     end
                  end
                  default: begin
                     w_flush    = 1'b1;
                     w_state_nx = S_IDLE;
                  end
               endcase
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      // watchdog spans the whole byte; a byte finishing on the last cycle still counts as done
      if (w_in_byte && !w_complete && (r_wdog == WDOG_LAST)) begin
         w_timeout_set = 1'b1;
         w_flush       = 1'b1;
         w_state_nx    = S_IDLE;
      end
   end

   always_comb begin
      gen_start   = (r_state == S_STARTP);
      busy        = (r_state != S_IDLE);
      gen_din     = r_din;
      gen_extend  = r_ext;
      fifo_full   = w_full;
      underrun    = r_underrun;
      timeout_err = r_timeout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_motor_q  <= 1'b0;
         r_stop     <= 1'b0;
         r_lcnt     <= '0;
         r_wdog     <= '0;
         r_din      <= '0;
         r_ext      <= 1'b0;
         r_phase    <= S_IDLE;
         r_underrun <= 1'b0;
         r_timeout  <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_motor_q <= motor_on;
         if (w_state_nx == S_IDLE)                r_stop <= 1'b0;
         else if (r_state != S_IDLE && !motor_on) r_stop <= 1'b1;

         if (w_start_session) r_lcnt <= LEADER_LEN;
         else if (w_lcnt_dec) r_lcnt <= r_lcnt - 16'd1;

         if (w_issue) begin
            r_din   <= w_issue_byte;
            r_ext   <= w_issue_ext;
            r_phase <= w_issue_phase;
            r_wdog  <= '0;
         end else if (w_in_byte) begin
            r_wdog  <= r_wdog + 24'd1;
         end

         if (w_start_session)     r_underrun <= 1'b0;
         else if (w_underrun_set) r_underrun <= 1'b1;
         if (w_start_session)     r_timeout  <= 1'b0;
         else if (w_timeout_set)  r_timeout  <= 1'b1;

         if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
         if (w_flush)    r_rptr <= r_wptr;
         else if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wptr[FIFO_AW-1:0]] <= wr_data;
   end

`ifdef CAS_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum  <= '0;
         r_sent <= 1'b0;
      end else if (w_start_session) begin
         r_sum  <= '0;
         r_sent <= 1'b0;
      end else if (w_pop) begin
         r_sum  <= r_sum + w_head;
         r_sent <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cas_tx_sequencer.sv
// Randomized bench for cas_tx_sequencer: a generator model answers the handshake and the
// observed byte stream is compared with the frame expected from the session rules.
module tb_cas_tx_sequencer;

   localparam int LEAD_N = 3;
   localparam int HOLD   = 4;
   localparam int TMO    = 100;
   localparam int DEPTH  = 8;

   logic       clk = 1'b0;
   logic       reset_n, motor_on, wr_en, gen_done;
   logic [7:0] wr_data;
   logic       fifo_full, busy, underrun, timeout_err, gen_start, gen_extend;
   logic [7:0] gen_din;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [8:0] q_obs[$];
   logic [8:0] q_exp[$];
   logic [7:0] q_pre[$];
   logic [7:0] q_late[$];
   bit         gen_stuck = 1'b0;

   cas_tx_sequencer #(
      .LEADER_LEN (16'd3),
      .START_HOLD (HOLD),
      .TIMEOUT    (24'd100)
   ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .motor_on    (motor_on),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .fifo_full   (fifo_full),
      .busy        (busy),
      .underrun    (underrun),
      .timeout_err (timeout_err),
      .gen_start   (gen_start),
      .gen_din     (gen_din),
      .gen_extend  (gen_extend),
      .gen_done    (gen_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // generator: done low from start until a random delay after start falls
   initial begin
      gen_done = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (gen_start) begin
            gen_done = 1'b0;
            for (int k = 0; k < 64 && gen_start; k++) begin @(posedge clk); #1; end
            while (gen_stuck) begin @(posedge clk); #1; end
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 gen_done = 1'b1;
         end
      end
   end

   // monitor: record each issued byte, its start width and din stability
   initial begin
      logic [8:0] cap;
      int         hold;
      bit         bad;
      forever begin
         @(negedge clk);
         if (gen_start && reset_n) begin
            cap  = {gen_extend, gen_din};
            q_obs.push_back(cap);
            hold = 0;
            bad  = 1'b0;
            while (gen_start && reset_n) begin
               hold++;
               if ({gen_extend, gen_din} !== cap) bad = 1'b1;
               @(negedge clk);
            end
            if (reset_n) begin
               check_eq("start_hold", 32'(hold), 32'(HOLD));
               for (int k = 0; k < 400 && !gen_done && reset_n && busy; k++) begin
                  if ({gen_extend, gen_din} !== cap) bad = 1'b1;
                  @(negedge clk);
               end
               if (gen_done && reset_n) check_eq("din_hold", 32'(bad), 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got=stuck expected=finish");
      $fatal(1);
   end

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (q_obs.size() >= n && gen_done && !gen_start) begin ok = 1'b1; break; end
      end
      check_eq("wait_bytes", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      check_eq("wait_idle", 32'(ok), 32'd1);
   endtask

   task automatic wait_underrun();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (underrun) begin ok = 1'b1; break; end
      end
      check_eq("underrun_set", 32'(ok), 32'd1);
   endtask

   task automatic wait_start(input logic [8:0] want, input bit any);
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (gen_start && (any || {gen_extend, gen_din} == want)) begin ok = 1'b1; break; end
      end
      check_eq("wait_start", 32'(ok), 32'd1);
   endtask

   task automatic expect_preamble();
      for (int i = 0; i < LEAD_N; i++) q_exp.push_back({1'b0, 8'h55});
      q_exp.push_back({1'b0, 8'h7F});
   endtask

   task automatic compare_streams(input string tag);
      check_eq({tag, "_count"}, 32'(q_obs.size()), 32'(q_exp.size()));
      for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++)
         check_eq(tag, 32'(q_obs[i]), 32'(q_exp[i]));
   endtask

   task automatic run_session();
      logic [7:0] data[$];
      logic [7:0] sum;
      sum = 8'd0;
      q_obs.delete();
      q_exp.delete();
      foreach (q_pre[i]) begin
         write_byte(q_pre[i]);
         if (data.size() < DEPTH) data.push_back(q_pre[i]);
      end
      check_eq("full_after_writes", 32'(fifo_full), 32'(q_pre.size() >= DEPTH));
      @(negedge clk);
      motor_on = 1'b1;
      @(negedge clk);
      check_eq("flags_clear", 32'({busy, underrun, timeout_err}), 32'b100);
      expect_preamble();
      foreach (data[i]) begin
         q_exp.push_back({1'b1, data[i]});
         sum = sum + data[i];
      end
      wait_bytes(q_exp.size());
      wait_underrun();
      foreach (q_late[i]) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         write_byte(q_late[i]);
         q_exp.push_back({1'b1, q_late[i]});
         sum = sum + q_late[i];
         data.push_back(q_late[i]);
      end
      wait_bytes(q_exp.size());
      repeat (4) @(negedge clk);
      motor_on = 1'b0;
`ifdef CAS_CHECKSUM_EN
      if (data.size() > 0) q_exp.push_back({1'b1, 8'd0 - sum});
`endif
      wait_idle();
      repeat (3) @(negedge clk);
      compare_streams("session");
   endtask

   initial begin
      reset_n  = 1'b0;
      motor_on = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("reset_outs", 32'({fifo_full, busy, underrun, timeout_err, gen_start, gen_extend, gen_din}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("post_reset_outs", 32'({fifo_full, busy, underrun, timeout_err, gen_start, gen_extend, gen_din}), 32'd0);

      // single byte after leader and sync
      q_pre.delete(); q_late.delete();
      q_pre.push_back(8'hA5);
      run_session();

      // nine writes while idle: eighth fills, ninth dropped
      q_pre.delete();
      for (int i = 0; i < 9; i++) q_pre.push_back(8'($urandom));
      run_session();

      for (int r = 0; r < 4; r++) begin
         q_pre.delete(); q_late.delete();
         repeat ($urandom_range(0, 10)) q_pre.push_back(8'($urandom));
         repeat ($urandom_range(0, 5))  q_late.push_back(8'($urandom));
         run_session();
      end
      q_late.delete();

      // generator never finishes: watchdog abandons the byte and flushes
      q_obs.delete();
      write_byte(8'h11);
      write_byte(8'h22);
      gen_stuck = 1'b1;
      @(negedge clk);
      motor_on = 1'b1;
      wait_start(9'h000, 1'b1);
      repeat (TMO - 1) @(negedge clk);
      check_eq("timeout_before", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check_eq("timeout_at", 32'(timeout_err), 32'd1);
      check_eq("timeout_idle", 32'({busy, gen_start}), 32'd0);
      gen_stuck = 1'b0;
      motor_on  = 1'b0;
      repeat (12) @(negedge clk);
      q_pre.delete();
      q_pre.push_back(8'($urandom));
      run_session();

      // motor drops while data byte 3C is in flight with two bytes queued
      q_obs.delete(); q_exp.delete();
      write_byte(8'h3C);
      write_byte(8'hAA);
      write_byte(8'hBB);
      @(negedge clk);
      motor_on = 1'b1;
      expect_preamble();
      q_exp.push_back({1'b1, 8'h3C});
`ifdef CAS_CHECKSUM_EN
      q_exp.push_back({1'b1, 8'hC4});
`endif
      wait_start({1'b1, 8'h3C}, 1'b0);
      motor_on = 1'b0;
      wait_idle();
      repeat (12) @(negedge clk);
      compare_streams("motor_drop");
      q_pre.delete();
      q_pre.push_back(8'($urandom));
      run_session();

      // async reset while gen_start is high
      q_obs.delete();
      @(negedge clk);
      motor_on = 1'b1;
      wait_underrun();
      write_byte(8'h5A);
      wait_start(9'h000, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("reset_start", 32'(gen_start), 32'd0);
      check_eq("reset_flags", 32'({fifo_full, busy, underrun, timeout_err, gen_extend, gen_din}), 32'd0);
      motor_on = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);

      q_pre.delete();
      q_pre.push_back(8'h01);
      q_pre.push_back(8'h02);
      q_pre.push_back(8'h03);
      run_session();
`ifdef CAS_CHECKSUM_EN
      check_eq("chksum_byte", 32'(q_obs.size() > 0 ? q_obs[q_obs.size()-1] : 9'h000), 32'h1FA);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
